fmul_36bit_norm: RTL and testbench
==================================

// Module: fmul_36bit_norm
// PURPOSE
// - Back end of the 36-bit FP multiplier: consumes the raw sign/exp/50b-product/exception bundle from the multiply stage.
// - Produces a packed, normalized, round-to-nearest-even 36-bit result {sign[35], exp[34:24], fract[23:0]} plus IEEE-style status flags.
// - Two-stage pipeline using the same valid/busy handshake as the multiply stage; sits between that stage and the result writeback.
// PARAMETERS
// - P_BIAS_ADJ  default 512  residual bias subtracted here; upstream EXP already carries sum-of-exps minus 511, total bias 1023.
// - P_EXP_MAX   default 2047 all-ones biased exponent, reserved for Inf/NaN.
// PORTS
// - iCLOCK                input  1   single clock, posedge.
// - iRESET                input  1   reset, asynchronous, active-high (one clock; reset is asynchronous and active-high).
// - iRESET_SYNC           input  1   synchronous clear, same effect as iRESET.
// - iDATA_REQ             input  1   upstream bundle valid.
// - oDATA_BUSY            output 1   stall to upstream; = iDATA_BUSY (combinational).
// - iDATA_SIGN            input  1   product sign.
// - iDATA_EXP             input  13  two's-complement exponent, still offset by P_BIAS_ADJ.
// - iDATA_FRACT           input  50  unsigned 25x25 significand product, value in [1,4) scaled by 2^48.
// - iDATA_EXCEPT_EXP_A0/B0     input 1 each  operand exponent all zero.
// - iDATA_EXCEPT_EXP_A1/B1     input 1 each  operand exponent all ones.
// - iDATA_EXCEPT_FRACT_A0/B0   input 1 each  operand fraction all zero.
// - oDATA_VALID           output 1   result valid.
// - iDATA_BUSY            input  1   downstream stall.
// - oDATA_RESULT          output 36  packed result.
// - oDATA_FLAG_INVALID / _OVERFLOW / _UNDERFLOW / _INEXACT  output 1 each  status.
// BEHAVIOUR
// - Reset (iRESET or iRESET_SYNC): all stage valids 0, oDATA_VALID=0, oDATA_RESULT=36'h0, all flags 0; in-flight data dropped.
// - Handshake: accept when iDATA_REQ && !oDATA_BUSY. Both stages load only when !iDATA_BUSY; when busy, every register holds.
// - Latency 2 cycles; throughput 1/cycle when not stalled; no bubble insertion, no data loss while stalled.
// - Stage 1 (special decode + normalize), e = 14b sign-extended iDATA_EXP - P_BIAS_ADJ:
//   - NaN = (A1&!FA0)|(B1&!FB0)|(A1&FA0&A0')... precisely: Inf*0 = ((A1&FA0)&B0)|((B1&FB0)&A0), or either operand NaN.
//   - Inf = (A1|B1) and not NaN; Zero = (A0|B0) and not NaN/Inf (subnormal inputs flushed to zero).
//   - FRACT[49]=1: mant=FRACT[48:25], guard=FRACT[24], sticky=|FRACT[23:0], e=e+1.
//   - FRACT[49]=0: mant=FRACT[47:24], guard=FRACT[23], sticky=|FRACT[22:0].
// - Stage 2 (round + pack):
//   - RNE: inc = guard & (sticky | mant[0]); 25b sum; carry-out -> mant=0, e=e+1.
//   - INEXACT = guard|sticky (normal path only).
//   - e >= P_EXP_MAX -> {sign, 11'h7FF, 24'h0}, OVERFLOW=1, INEXACT=1.
//   - e <= 0 -> {sign, 35'h0}, UNDERFLOW=1, INEXACT=1 (flush-to-zero, no subnormal output).
//   - NaN -> canonical 36'h7FF800000, INVALID=1; Inf -> {sign,11'h7FF,24'h0}; Zero -> {sign,35'h0}; these set no other flags.
//   - Priority: NaN > Inf > Zero > overflow > underflow > normal.
// - Flags are per-result, qualified by oDATA_VALID; not sticky.
// STRUCTURE
// - Package fmul36_pkg: field widths (SIGN/EXP=11/FRACT=24), bias constant 1023, P_EXP_MAX, canonical NaN 36'h7FF800000, typedef struct for the stage-1 bundle (sign, e[13:0], mant, guard, sticky, nan/inf/zero).
// - One sub-module: fmul_pipe_reg #(W): valid+data register, loads on !iDATA_BUSY, cleared by both resets; instantiated once per stage.
// TESTING
// - 1.0*1.0: SIGN=0, EXP=13'd1535, FRACT=50'h1_0000_0000_0000 -> RESULT=36'h3FF000000 two cycles later, no flags.
// - 1.5*1.5: EXP=13'd1535, FRACT=50'h2_4000_0000_0000 -> RESULT=36'h400200000, INEXACT=0.
// - RNE: FRACT=50'h1_0000_0080_0000 -> mant 0 (tie to even, INEXACT=1); FRACT=50'h1_0000_0180_0000 -> mant 24'h000002, INEXACT=1.
// - Overflow: EXP=13'd3584 -> RESULT={SIGN,11'h7FF,24'h0}, OVERFLOW=1; EXP=13'd512 -> signed zero, UNDERFLOW=1.
// - Specials: A1=1,FA0=0 -> 36'h7FF800000, INVALID=1; A1=1,FA0=1,B0=1 -> NaN, INVALID=1; A1=1,FA0=1,B normal -> signed Inf, no flags.
// - Stall/reset: back-to-back 4 inputs, iDATA_BUSY high 3 cycles mid-stream -> outputs held stable, all 4 delivered in order; iRESET pulse with 2 in flight -> oDATA_VALID=0 next edge, none delivered.

Source files
------------

// File: rtl/fmul_36bit_norm_pkg.sv
// Shared widths, constants and stage bundles for the 36-bit FP multiplier back end.
// Result format: {sign[35], exp[34:24], fract[23:0]}, exponent bias 1023.
package fmul36_pkg;

  localparam int SIGN_W  = 1;
  localparam int EXP_W   = 11;
  localparam int FRACT_W = 24;
  localparam int BIAS    = 1023;
  localparam int EXP_MAX = 2047;

  localparam logic [35:0] CANON_NAN = 36'h7FF800000;

  // Normalized but unrounded product, carried from stage 1 to stage 2.
  typedef struct packed {
    logic        sign;
    logic [13:0] e;
    logic [23:0] mant;
    logic        guard;
    logic        sticky;
    logic        nan;
    logic        inf;
    logic        zero;
  } s1_t;

  typedef struct packed {
    logic [35:0] result;
    logic        invalid;
    logic        overflow;
    logic        underflow;
    logic        inexact;
  } s2_t;

endpackage

// File: rtl/fmul_36bit_norm_if.sv
// Upstream bundle (multiply stage) and downstream result port of the normalizer.
// Handshake: a beat moves when REQ/VALID is high and the receiver's BUSY is low; BUSY stalls everything.
interface fmul_36bit_norm_if;
  logic        iDATA_REQ;
  logic        oDATA_BUSY;
  logic        iDATA_SIGN;
  logic [12:0] iDATA_EXP;
  logic [49:0] iDATA_FRACT;
  logic        iDATA_EXCEPT_EXP_A0;
  logic        iDATA_EXCEPT_EXP_B0;
  logic        iDATA_EXCEPT_EXP_A1;
  logic        iDATA_EXCEPT_EXP_B1;
  logic        iDATA_EXCEPT_FRACT_A0;
  logic        iDATA_EXCEPT_FRACT_B0;
  logic        oDATA_VALID;
  logic        iDATA_BUSY;
  logic [35:0] oDATA_RESULT;
  logic        oDATA_FLAG_INVALID;
  logic        oDATA_FLAG_OVERFLOW;
  logic        oDATA_FLAG_UNDERFLOW;
  logic        oDATA_FLAG_INEXACT;

  modport master (
    output iDATA_REQ, iDATA_SIGN, iDATA_EXP, iDATA_FRACT,
           iDATA_EXCEPT_EXP_A0, iDATA_EXCEPT_EXP_B0, iDATA_EXCEPT_EXP_A1,
           iDATA_EXCEPT_EXP_B1, iDATA_EXCEPT_FRACT_A0, iDATA_EXCEPT_FRACT_B0,
           iDATA_BUSY,
    input  oDATA_BUSY, oDATA_VALID, oDATA_RESULT, oDATA_FLAG_INVALID,
           oDATA_FLAG_OVERFLOW, oDATA_FLAG_UNDERFLOW, oDATA_FLAG_INEXACT
  );

  modport slave (
    input  iDATA_REQ, iDATA_SIGN, iDATA_EXP, iDATA_FRACT,
           iDATA_EXCEPT_EXP_A0, iDATA_EXCEPT_EXP_B0, iDATA_EXCEPT_EXP_A1,
           iDATA_EXCEPT_EXP_B1, iDATA_EXCEPT_FRACT_A0, iDATA_EXCEPT_FRACT_B0,
           iDATA_BUSY,
    output oDATA_BUSY, oDATA_VALID, oDATA_RESULT, oDATA_FLAG_INVALID,
           oDATA_FLAG_OVERFLOW, oDATA_FLAG_UNDERFLOW, oDATA_FLAG_INEXACT
  );
endinterface

// File: rtl/fmul_36bit_norm_pipe_reg.sv
// Valid + data pipeline register; holds while the downstream is busy.
// Data only loads on a valid beat so the output keeps the last real result.
module fmul_pipe_reg #(
  parameter int W = 8
) (
  input  logic         iCLOCK,
  input  logic         iRESET,
  input  logic         iRESET_SYNC,
  input  logic         iDATA_BUSY,
  input  logic         iVALID,
  input  logic [W-1:0] iDATA,
  output logic         oVALID,
  output logic [W-1:0] oDATA
);

  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      oVALID <= 1'b0;
      oDATA  <= '0;
    end else if (iRESET_SYNC) begin
      oVALID <= 1'b0;
      oDATA  <= '0;
    end else if (!iDATA_BUSY) begin
      oVALID <= iVALID;
      if (iVALID) oDATA <= iDATA;
    end
  end

endmodule

// File: rtl/fmul_36bit_norm.sv
// Normalize, round-to-nearest-even and pack the raw 36-bit FP product.
// Stage 1 decodes specials and normalizes; stage 2 rounds, range-checks and packs.
module fmul_36bit_norm
  import fmul36_pkg::*;
#(
  parameter int P_BIAS_ADJ = 512,
  parameter int P_EXP_MAX  = 2047
) (
  input  logic           iCLOCK,
  input  logic           iRESET,
  input  logic           iRESET_SYNC,
  fmul_36bit_norm_if.slave bus
);

  s1_t         s1_d;
  s1_t         s1_q;
  logic        s1_valid;
  s2_t         s2_d;
  s2_t         s2_q;
  logic        s2_valid;
  logic        inc;
  logic [24:0] sum;
  logic [13:0] e_rnd;
  logic        a0, b0, a1, b1, fa0, fb0;

  assign bus.oDATA_BUSY = bus.iDATA_BUSY;

  assign a0  = bus.iDATA_EXCEPT_EXP_A0;
  assign b0  = bus.iDATA_EXCEPT_EXP_B0;
  assign a1  = bus.iDATA_EXCEPT_EXP_A1;
  assign b1  = bus.iDATA_EXCEPT_EXP_B1;
  assign fa0 = bus.iDATA_EXCEPT_FRACT_A0;
  assign fb0 = bus.iDATA_EXCEPT_FRACT_B0;

  always_comb begin
    s1_d      = '0;
    s1_d.sign = bus.iDATA_SIGN;
    s1_d.e    = {bus.iDATA_EXP[12], bus.iDATA_EXP} - 14'(P_BIAS_ADJ);
    // NaN operand, or Inf times zero
    s1_d.nan  = (a1 & ~fa0) | (b1 & ~fb0) | (a1 & fa0 & b0) | (b1 & fb0 & a0);
    s1_d.inf  = (a1 | b1) & ~s1_d.nan;
    s1_d.zero = (a0 | b0) & ~s1_d.nan & ~s1_d.inf;
    if (bus.iDATA_FRACT[49]) begin
      s1_d.mant   = bus.iDATA_FRACT[48:25];
      s1_d.guard  = bus.iDATA_FRACT[24];
      s1_d.sticky = |bus.iDATA_FRACT[23:0];
      s1_d.e      = s1_d.e + 14'd1;
    end else begin
      s1_d.mant   = bus.iDATA_FRACT[47:24];
      s1_d.guard  = bus.iDATA_FRACT[23];
      s1_d.sticky = |bus.iDATA_FRACT[22:0];
    end
  end

  fmul_pipe_reg #(.W($bits(s1_t))) u_stage1 (
    .iCLOCK      (iCLOCK),
    .iRESET      (iRESET),
    .iRESET_SYNC (iRESET_SYNC),
    .iDATA_BUSY  (bus.iDATA_BUSY),
    .iVALID      (bus.iDATA_REQ),
    .iDATA       (s1_d),
    .oVALID      (s1_valid),
    .oDATA       (s1_q)
  );

  always_comb begin
    inc   = s1_q.guard & (s1_q.sticky | s1_q.mant[0]);
    sum   = {1'b0, s1_q.mant} + {24'd0, inc};
    // mantissa carry-out: sum[23:0] is already zero, only the exponent moves
    e_rnd = s1_q.e + {13'd0, sum[24]};
    s2_d  = '0;
    if (s1_q.nan) begin
      s2_d.result  = CANON_NAN;
      s2_d.invalid = 1'b1;
    end else if (s1_q.inf) begin
      s2_d.result = {s1_q.sign, 11'h7FF, 24'h0};
    end else if (s1_q.zero) begin
      s2_d.result = {s1_q.sign, 35'h0};
    end else if ($signed(e_rnd) >= $signed(14'(P_EXP_MAX))) begin
      s2_d.result   = {s1_q.sign, 11'h7FF, 24'h0};
      s2_d.overflow = 1'b1;
      s2_d.inexact  = 1'b1;
    end else if ($signed(e_rnd) <= 14'sd0) begin
      s2_d.result    = {s1_q.sign, 35'h0};
      s2_d.underflow = 1'b1;
      s2_d.inexact   = 1'b1;
    end else begin
      s2_d.result  = {s1_q.sign, e_rnd[10:0], sum[23:0]};
      s2_d.inexact = s1_q.guard | s1_q.sticky;
    end
  end

  fmul_pipe_reg #(.W($bits(s2_t))) u_stage2 (
    .iCLOCK      (iCLOCK),
    .iRESET      (iRESET),
    .iRESET_SYNC (iRESET_SYNC),
    .iDATA_BUSY  (bus.iDATA_BUSY),
    .iVALID      (s1_valid),
    .iDATA       (s2_d),
    .oVALID      (s2_valid),
    .oDATA       (s2_q)
  );

  assign bus.oDATA_VALID          = s2_valid;
  assign bus.oDATA_RESULT         = s2_q.result;
  assign bus.oDATA_FLAG_INVALID   = s2_q.invalid;
  assign bus.oDATA_FLAG_OVERFLOW  = s2_q.overflow;
  assign bus.oDATA_FLAG_UNDERFLOW = s2_q.underflow;
  assign bus.oDATA_FLAG_INEXACT   = s2_q.inexact;

endmodule

// File: tb/tb_fmul_36bit_norm.sv
// Self-checking bench for fmul_36bit_norm: directed cases, stall, resets, random normals.
// Expected words are {result[35:0], invalid, overflow, underflow, inexact}.
module tb_fmul_36bit_norm;

  logic iCLOCK;
  logic iRESET;
  logic iRESET_SYNC;

  fmul_36bit_norm_if bus ();

  fmul_36bit_norm dut (
    .iCLOCK      (iCLOCK),
    .iRESET      (iRESET),
    .iRESET_SYNC (iRESET_SYNC),
    .bus         (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [39:0] exp_q[$];
  string       name_q[$];
  logic [39:0] got;

  // ---------------- clock / reset ----------------
  initial iCLOCK = 1'b0;
  always #5 iCLOCK = ~iCLOCK;

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge iCLOCK) begin
    if (!iRESET && !iRESET_SYNC && bus.oDATA_VALID) begin
      got = {bus.oDATA_RESULT, bus.oDATA_FLAG_INVALID, bus.oDATA_FLAG_OVERFLOW,
             bus.oDATA_FLAG_UNDERFLOW, bus.oDATA_FLAG_INEXACT};
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_output got=%h want=none", got);
      end else begin
        if (got !== exp_q[0]) begin
          bad++;
          $display("FAIL %s got=%h want=%h", name_q[0], got, exp_q[0]);
        end
        if (!bus.iDATA_BUSY) begin
          void'(exp_q.pop_front());
          void'(name_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic sign, input logic [12:0] e, input logic [49:0] f,
                       input logic [5:0] exc);
    bus.iDATA_REQ             = 1'b1;
    bus.iDATA_SIGN            = sign;
    bus.iDATA_EXP             = e;
    bus.iDATA_FRACT           = f;
    bus.iDATA_EXCEPT_EXP_A0   = exc[5];
    bus.iDATA_EXCEPT_EXP_B0   = exc[4];
    bus.iDATA_EXCEPT_EXP_A1   = exc[3];
    bus.iDATA_EXCEPT_EXP_B1   = exc[2];
    bus.iDATA_EXCEPT_FRACT_A0 = exc[1];
    bus.iDATA_EXCEPT_FRACT_B0 = exc[0];
  endtask

  // exc = {A0, B0, A1, B1, FA0, FB0}; assumes iDATA_BUSY is low for the accept edge
  task automatic send(input string name, input logic sign, input logic [12:0] e,
                      input logic [49:0] f, input logic [5:0] exc, input logic [39:0] expv);
    drive(sign, e, f, exc);
    exp_q.push_back(expv);
    name_q.push_back(name);
    @(posedge iCLOCK); #1;
  endtask

  task automatic idle(input int n);
    bus.iDATA_REQ = 1'b0;
    repeat (n) begin
      @(posedge iCLOCK); #1;
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    bus.iDATA_REQ = 1'b0;
    while (exp_q.size() != 0 && n < 40) begin
      @(posedge iCLOCK); #1;
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_drain pending=%0d want=0", name, exp_q.size());
      exp_q.delete();
      name_q.delete();
    end
  endtask

  // Independent reference: integer shift/remainder rounding of the raw product.
  function automatic logic [39:0] model(input logic sign, input logic [12:0] e_in,
                                        input logic [49:0] f);
    int          e;
    int          sh;
    logic [49:0] q, r, half;
    logic        ix;
    sh   = f[49] ? 25 : 24;
    e    = int'($signed(e_in)) - 512 + (f[49] ? 1 : 0);
    q    = f >> sh;
    r    = f & ((50'd1 << sh) - 50'd1);
    half = 50'd1 << (sh - 1);
    if (r > half || (r == half && q[0])) q = q + 50'd1;
    if (q[25]) begin
      q = q >> 1;
      e = e + 1;
    end
    ix = (r != 50'd0);
    if (e >= 2047) return {sign, 11'h7FF, 24'h0, 4'b0101};
    if (e <= 0) return {sign, 35'h0, 4'b0011};
    return {sign, e[10:0], q[23:0], 3'b000, ix};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    total++;
    if (bus.oDATA_VALID !== 1'b0) begin
      bad++; $display("FAIL reset_valid got=%b want=0", bus.oDATA_VALID);
    end
    total++;
    if (bus.oDATA_RESULT !== 36'h0) begin
      bad++; $display("FAIL reset_result got=%h want=000000000", bus.oDATA_RESULT);
    end
    total++;
    if ({bus.oDATA_FLAG_INVALID, bus.oDATA_FLAG_OVERFLOW, bus.oDATA_FLAG_UNDERFLOW,
         bus.oDATA_FLAG_INEXACT} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags got=%b%b%b%b want=0000", bus.oDATA_FLAG_INVALID,
                      bus.oDATA_FLAG_OVERFLOW, bus.oDATA_FLAG_UNDERFLOW, bus.oDATA_FLAG_INEXACT);
    end
  endtask

  task automatic test_normal();
    send("one_x_one",   1'b0, 13'd1535, 50'h1_0000_0000_0000, 6'b0, {36'h3FF000000, 4'b0000});
    idle(3);
    send("onehalf_sq",  1'b0, 13'd1535, 50'h2_4000_0000_0000, 6'b0, {36'h400200000, 4'b0000});
    send("neg_one",     1'b1, 13'd1535, 50'h1_0000_0000_0000, 6'b0, {36'hBFF000000, 4'b0000});
    send("min_normal",  1'b0, 13'd513,  50'h1_0000_0000_0000, 6'b0, {36'h001000000, 4'b0000});
    send("max_normal",  1'b0, 13'd2558, 50'h1_0000_0000_0000, 6'b0, {36'h7FE000000, 4'b0000});
    wait_drain("normal");
  endtask

  task automatic test_rounding();
    send("rne_tie_even", 1'b0, 13'd1535, 50'h1_0000_0080_0000, 6'b0, {36'h3FF000000, 4'b0001});
    send("rne_tie_up",   1'b0, 13'd1535, 50'h1_0000_0180_0000, 6'b0, {36'h3FF000002, 4'b0001});
    send("rne_sticky",   1'b0, 13'd1535, 50'h1_0000_0080_0001, 6'b0, {36'h3FF000001, 4'b0001});
    send("rnd_carry",    1'b0, 13'd1535, 50'h1_FFFF_FF80_0000, 6'b0, {36'h400000000, 4'b0001});
    wait_drain("rounding");
  endtask

  task automatic test_range();
    send("ovf_big",      1'b1, 13'd3000, 50'h1_0000_0000_0000, 6'b0, {36'hFFF000000, 4'b0101});
    send("ovf_edge",     1'b0, 13'd2559, 50'h1_0000_0000_0000, 6'b0, {36'h7FF000000, 4'b0101});
    send("ovf_by_carry", 1'b0, 13'd2558, 50'h1_FFFF_FF80_0000, 6'b0, {36'h7FF000000, 4'b0101});
    send("unf_edge",     1'b1, 13'd512,  50'h1_0000_0000_0000, 6'b0, {36'h800000000, 4'b0011});
    send("unf_negexp",   1'b0, 13'h1F00, 50'h1_0000_0000_0000, 6'b0, {36'h000000000, 4'b0011});
    wait_drain("range");
  endtask

  task automatic test_specials();
    send("nan_a",      1'b1, 13'd3000, 50'h1_0000_0000_0000, 6'b001000, {36'h7FF800000, 4'b1000});
    send("nan_b",      1'b0, 13'd1535, 50'h1_0000_0000_0000, 6'b000100, {36'h7FF800000, 4'b1000});
    send("inf_x_zero", 1'b0, 13'd1535, 50'h1_0000_0000_0000, 6'b011010, {36'h7FF800000, 4'b1000});
    send("zero_x_inf", 1'b1, 13'd1535, 50'h1_0000_0000_0000, 6'b100101, {36'h7FF800000, 4'b1000});
    send("inf_a",      1'b1, 13'd512,  50'h1_0000_0000_0000, 6'b001010, {36'hFFF000000, 4'b0000});
    send("inf_b",      1'b0, 13'd1535, 50'h1_0000_0000_0000, 6'b000101, {36'h7FF000000, 4'b0000});
    send("zero_a",     1'b1, 13'd3000, 50'h1_0000_0000_0000, 6'b100000, {36'h800000000, 4'b0000});
    send("zero_b",     1'b0, 13'd1535, 50'h1_FFFF_FF80_0000, 6'b010000, {36'h000000000, 4'b0000});
    wait_drain("specials");
  endtask

  task automatic test_back_to_back();
    send("stall_a", 1'b0, 13'd1535, 50'h1_0000_0000_0000, 6'b0, {36'h3FF000000, 4'b0000});
    send("stall_b", 1'b0, 13'd1535, 50'h2_4000_0000_0000, 6'b0, {36'h400200000, 4'b0000});
    drive(1'b1, 13'd1535, 50'h1_0000_0180_0000, 6'b0);
    bus.iDATA_BUSY = 1'b1;
    repeat (3) begin
      @(posedge iCLOCK); #1;
      total++;
      if (bus.oDATA_BUSY !== 1'b1) begin
        bad++; $display("FAIL busy_passthru got=%b want=1", bus.oDATA_BUSY);
      end
    end
    bus.iDATA_BUSY = 1'b0;
    total++;
    if (bus.oDATA_BUSY !== 1'b0) begin
      bad++; $display("FAIL busy_release got=%b want=0", bus.oDATA_BUSY);
    end
    send("stall_c", 1'b1, 13'd1535, 50'h1_0000_0180_0000, 6'b0, {36'hBFF000002, 4'b0001});
    send("stall_d", 1'b0, 13'd3000, 50'h1_0000_0000_0000, 6'b0, {36'h7FF000000, 4'b0101});
    wait_drain("back_to_back");
  endtask

  task automatic test_reset_in_flight();
    send("rst_a", 1'b0, 13'd1535, 50'h1_0000_0000_0000, 6'b0, {36'h3FF000000, 4'b0000});
    send("rst_b", 1'b0, 13'd1535, 50'h2_4000_0000_0000, 6'b0, {36'h400200000, 4'b0000});
    bus.iDATA_REQ = 1'b0;
    iRESET = 1'b1;
    exp_q.delete();
    name_q.delete();
    #1;
    total++;
    if (bus.oDATA_VALID !== 1'b0) begin
      bad++; $display("FAIL async_rst_valid got=%b want=0", bus.oDATA_VALID);
    end
    @(posedge iCLOCK); #1;
    iRESET = 1'b0;
    idle(5);

    send("srst_a", 1'b0, 13'd1535, 50'h1_0000_0000_0000, 6'b0, {36'h3FF000000, 4'b0000});
    send("srst_b", 1'b0, 13'd1535, 50'h2_4000_0000_0000, 6'b0, {36'h400200000, 4'b0000});
    bus.iDATA_REQ = 1'b0;
    iRESET_SYNC = 1'b1;
    exp_q.delete();
    name_q.delete();
    @(posedge iCLOCK); #1;
    iRESET_SYNC = 1'b0;
    total++;
    if (bus.oDATA_VALID !== 1'b0 || bus.oDATA_RESULT !== 36'h0) begin
      bad++; $display("FAIL sync_rst_clear got=%b/%h want=0/000000000",
                      bus.oDATA_VALID, bus.oDATA_RESULT);
    end
    idle(5);
  endtask

  task automatic test_random();
    logic        sign;
    logic [12:0] e;
    logic [49:0] f;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.iDATA_REQ  = 1'b0;
        bus.iDATA_BUSY = 1'b1;
        repeat ($urandom_range(1, 3)) begin
          @(posedge iCLOCK); #1;
        end
        bus.iDATA_BUSY = 1'b0;
      end
      sign = 1'($urandom_range(0, 1));
      e    = 13'($urandom_range(490, 2580));
      f    = {18'($urandom), 32'($urandom)};
      if ($urandom_range(0, 1) == 1) f[49] = 1'b1;
      else begin
        f[49] = 1'b0;
        f[48] = 1'b1;
      end
      if ($urandom_range(0, 4) == 0) f[22:0] = 23'd0;
      send("random", sign, e, f, 6'b0, model(sign, e, f));
    end
    wait_drain("random");
  endtask

  // ---------------- main sequence ----------------
  initial begin
    iRESET      = 1'b1;
    iRESET_SYNC = 1'b0;
    bus.iDATA_BUSY = 1'b0;
    drive(1'b0, 13'd0, 50'd0, 6'b0);
    bus.iDATA_REQ = 1'b0;
    repeat (2) @(posedge iCLOCK);
    #1;
    iRESET = 1'b0;
    test_reset();
    test_normal();
    test_rounding();
    test_range();
    test_specials();
    test_back_to_back();
    test_reset_in_flight();
    test_random();
    idle(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
